dc_motor_ramp_sequencer: RTL and testbench

Wishbone-configured sequencer that drives the duty-cycle input of the DC motor PWM generator. It ramps the commanded duty toward a software target in 1 % steps at a programmable rate. Direction reversals are made safe by ramping to 0 %, waiting a dead time, then flipping direction. It sits between the Wishbone bus and the PWM block and presents duty in percent, the same unit the PWM's width register accepts.

---
 rtl/dc_motor_pkg.sv | 24 ++
 rtl/dc_motor_if.sv | 23 ++
 rtl/dc_motor_step_timer.sv | 26 ++
 rtl/dc_motor_ramp_sequencer.sv | 173 +++++++++++++++++
 tb/tb_dc_motor_ramp_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dc_motor_pkg.sv
// Shared types and constants for the DC motor duty-ramp sequencer.
package dc_motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STOP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_TARGET   = 2'd1;
  localparam logic [1:0] REG_STEP_DIV = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int DUTY_MAX_DEF = 100;

  // Full-word compare so e.g. 150 (0x96) clamps instead of wrapping to 22.
  function automatic logic [6:0] clamp_pct(input logic [31:0] v, input logic [6:0] max_pct);
    return (v > 32'(max_pct)) ? max_pct : v[6:0];
  endfunction

endpackage

// File: rtl/dc_motor_if.sv
// Wishbone classic slave bus bundle for the sequencer register block.
// Handshake: a request is cyc&stb; the slave answers with a single-cycle ack
// one cycle later, write data commits on the ack edge, read data is valid with ack.
interface dc_motor_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    input  wb_ack, wb_dat_o
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    output wb_ack, wb_dat_o
  );
endinterface

// File: rtl/dc_motor_step_timer.sv
// Free-running ramp-step prescaler: one-cycle tick every div cycles (div=0 acts as 1).
module dc_motor_step_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div,
  input  logic        restart,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] last;

  assign last = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign tick = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (restart || tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/dc_motor_ramp_sequencer.sv
// Wishbone-configured duty ramp sequencer: ramps duty_pct toward TARGET one
// percent per step tick and makes direction reversals via drain, dead time, flip.
module dc_motor_ramp_sequencer
  import dc_motor_pkg::*;
#(
  parameter int STEP_DIV_RST = 50000,
  parameter int DEAD_CYCLES  = 100000,
  parameter int DUTY_MAX     = DUTY_MAX_DEF
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  dc_motor_if.slave   wb,
  output logic [6:0]  duty_pct,
  output logic        duty_wr,
  output logic        motor_dir,
  output state_t      dbg_state
);

  localparam logic [6:0] DMAX      = 7'(DUTY_MAX);
  localparam int         DCW       = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_CYCLES - 1);

  // Bus-side registers
  logic        ctrl_en;
  logic        ctrl_dir_req;
  logic [6:0]  target;
  logic [15:0] step_div;

  logic        req;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_step;
  logic        estop;
  logic [31:0] rd_mux;
  logic        tick;
  logic        unused_bits;

  // FSM state
  state_t          state, state_nxt;
  logic [6:0]      duty_nxt;
  logic            dir_nxt;
  logic [DCW-1:0]  dead_cnt, dead_nxt;

  assign req     = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack;
  assign wr_en   = req & wb.wb_we;
  assign wr_ctrl = wr_en && (wb.wb_adr[3:2] == REG_CTRL);
  assign wr_step = wr_en && (wb.wb_adr[3:2] == REG_STEP_DIV);
  assign estop   = wr_ctrl & wb.wb_dat_i[2];
  assign unused_bits = ^{wb.wb_sel, wb.wb_adr[31:4], wb.wb_adr[1:0]};
  assign dbg_state = state;

  always_comb begin
    rd_mux = 32'd0;
    case (wb.wb_adr[3:2])
      REG_CTRL:     rd_mux = {30'd0, ctrl_dir_req, ctrl_en};
      REG_TARGET:   rd_mux = {25'd0, target};
      REG_STEP_DIV: rd_mux = {16'd0, step_div};
      default:      rd_mux = {19'd0, (duty_pct == target), state, motor_dir, 1'b0, duty_pct};
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb.wb_ack    <= 1'b0;
      wb.wb_dat_o  <= 32'd0;
      ctrl_en      <= 1'b0;
      ctrl_dir_req <= 1'b0;
      target       <= 7'd0;
      step_div     <= 16'(STEP_DIV_RST);
    end else begin
      wb.wb_ack   <= req;
      wb.wb_dat_o <= (req && !wb.wb_we) ? rd_mux : 32'd0;
      if (wr_ctrl) begin
        ctrl_en      <= wb.wb_dat_i[0] & ~wb.wb_dat_i[2];
        ctrl_dir_req <= wb.wb_dat_i[1];
      end
      if (wr_en && (wb.wb_adr[3:2] == REG_TARGET)) begin
        target <= clamp_pct(wb.wb_dat_i, DMAX);
      end
      if (wr_step) begin
        step_div <= wb.wb_dat_i[15:0];
      end
    end
  end

  dc_motor_step_timer u_step_timer (
    .clk     (wb_clk),
    .rst_n   (wb_rst_n),
    .div     (step_div),
    .restart (wr_step),
    .tick    (tick)
  );

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= ST_IDLE;
      duty_pct  <= 7'd0;
      duty_wr   <= 1'b0;
      motor_dir <= 1'b0;
      dead_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      duty_pct  <= duty_nxt;
      duty_wr   <= (duty_nxt != duty_pct);
      motor_dir <= dir_nxt;
      dead_cnt  <= dead_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_pct;
    dir_nxt   = motor_dir;
    dead_nxt  = dead_cnt;
    case (state)
      ST_IDLE: begin
        duty_nxt = 7'd0;
        if (ctrl_en) begin
          state_nxt = ST_RUN;
          dir_nxt   = ctrl_dir_req;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (duty_pct < target)      duty_nxt = duty_pct + 7'd1;
          else if (duty_pct > target) duty_nxt = duty_pct - 7'd1;
        end
        if (!ctrl_en)                       state_nxt = ST_STOP;
        else if (ctrl_dir_req != motor_dir) state_nxt = ST_DRAIN;
      end
      ST_STOP: begin
        if (duty_pct == 7'd0) state_nxt = ST_IDLE;
        else if (tick)        duty_nxt  = duty_pct - 7'd1;
      end
      ST_DRAIN: begin
        // Priority: stop request, then cancelled reversal, then drain progress.
        if (!ctrl_en) begin
          state_nxt = ST_STOP;
        end else if (ctrl_dir_req == motor_dir) begin
          state_nxt = ST_RUN;
        end else if (duty_pct == 7'd0) begin
          state_nxt = ST_DEAD;
          dead_nxt  = '0;
        end else if (tick) begin
          duty_nxt = duty_pct - 7'd1;
        end
      end
      ST_DEAD: begin
        duty_nxt = 7'd0;
        if (!ctrl_en) begin
          state_nxt = ST_IDLE;
          dead_nxt  = '0;
        end else if (dead_cnt == DEAD_LAST) begin
          state_nxt = ST_RUN;
          dir_nxt   = ~motor_dir;
          dead_nxt  = '0;
        end else begin
          dead_nxt = dead_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        duty_nxt  = 7'd0;
      end
    endcase
    if (estop) begin
      state_nxt = ST_IDLE;
      duty_nxt  = 7'd0;
      dead_nxt  = '0;
    end
  end

endmodule

// File: tb/tb_dc_motor_ramp_sequencer.sv
// Self-checking bench for dc_motor_ramp_sequencer: register vector table plus
// hand-written ramp, reversal, ESTOP, cancelled-reversal and reset sequences.
module tb_dc_motor_ramp_sequencer;
  import dc_motor_pkg::*;

  localparam int STEP_DIV_RST = 1234;
  localparam int DEAD_CYCLES  = 20;
  localparam int DUTY_MAX     = 100;

  logic       clk;
  logic       rst_n;
  logic [6:0] duty_pct;
  logic       duty_wr;
  logic       motor_dir;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  dc_motor_if bus();

  dc_motor_ramp_sequencer #(
    .STEP_DIV_RST (STEP_DIV_RST),
    .DEAD_CYCLES  (DEAD_CYCLES),
    .DUTY_MAX     (DUTY_MAX)
  ) dut (
    .wb_clk    (clk),
    .wb_rst_n  (rst_n),
    .wb        (bus),
    .duty_pct  (duty_pct),
    .duty_wr   (duty_wr),
    .motor_dir (motor_dir),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Driver tasks
  task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_sel   = 4'hf;
    bus.wb_adr   = {28'd0, idx, 2'b00};
    bus.wb_dat_i = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wb_ack && n < 8);
    check("ack_latency", n, 1);
    rd = bus.wb_dat_o;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, wd, dummy);
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] rd);
    wb_xfer(1'b0, idx, 32'd0, rd);
  endtask

  // Waits for n duty_wr pulses; checks each duty value and the spacing between them.
  task automatic expect_steps(input string name, input int n, input int first,
                              input int delta, input int spacing);
    int k;
    int gap;
    int budget;
    k = 0;
    gap = 0;
    budget = (n + 2) * (spacing + 2) + 20;
    while (k < n && budget > 0) begin
      @(posedge clk); #1;
      gap++;
      budget--;
      if (duty_wr) begin
        check($sformatf("%s_duty%0d", name, k), int'(duty_pct), first + delta * k);
        if (k > 0) check($sformatf("%s_gap%0d", name, k), gap, spacing);
        gap = 0;
        k++;
      end
    end
    check($sformatf("%s_pulses", name), k, n);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  idx;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rd;
    int n;

    vecs[0] = '{"tgt_150_clamp", REG_TARGET,   1'b1, 32'd150,        32'd100};
    vecs[1] = '{"tgt_101_clamp", REG_TARGET,   1'b1, 32'd101,        32'd100};
    vecs[2] = '{"tgt_100",       REG_TARGET,   1'b1, 32'd100,        32'd100};
    vecs[3] = '{"tgt_37",        REG_TARGET,   1'b1, 32'd37,         32'd37};
    vecs[4] = '{"div_low16",     REG_STEP_DIV, 1'b1, 32'h0001_0005,  32'd5};
    vecs[5] = '{"div_zero",      REG_STEP_DIV, 1'b1, 32'd0,          32'd0};
    vecs[6] = '{"ctrl_estop_rd", REG_CTRL,     1'b1, 32'd6,          32'd2};
    vecs[7] = '{"ctrl_clear",    REG_CTRL,     1'b1, 32'd0,          32'd0};
    vecs[8] = '{"tgt_0",         REG_TARGET,   1'b1, 32'd0,          32'd0};
    vecs[9] = '{"status_idle",   REG_STATUS,   1'b0, 32'd0,          32'h1000};

    rst_n = 1'b0;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_sel = 4'h0; bus.wb_adr = 32'd0; bus.wb_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", int'(bus.wb_ack), 0);
    check("rst_dat_o", int'(bus.wb_dat_o), 0);
    check("rst_duty", int'(duty_pct), 0);
    check("rst_duty_wr", int'(duty_wr), 0);
    check("rst_dir", int'(motor_dir), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    wb_read(REG_CTRL, rd);     check("rst_ctrl", int'(rd), 0);
    wb_read(REG_TARGET, rd);   check("rst_target", int'(rd), 0);
    wb_read(REG_STEP_DIV, rd); check("rst_step_div", int'(rd), STEP_DIV_RST);
    wb_read(REG_STATUS, rd);   check("rst_status", int'(rd), 32'h1000);

    // Register vector table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) wb_write(vecs[i].idx, vecs[i].wdata);
      wb_read(vecs[i].idx, rd);
      check(vecs[i].name, int'(rd), int'(vecs[i].exp_rd));
    end
    check("table_duty_quiet", int'(duty_pct), 0);

    // Ramp up 0 -> 5 at 10 cycles per step
    wb_write(REG_STEP_DIV, 32'd10);
    wb_write(REG_TARGET, 32'd5);
    wb_write(REG_CTRL, 32'd1);
    check("en_commit_still_idle", int'(dbg_state), int'(ST_IDLE));
    @(posedge clk); #1;
    check("en_plus1_run", int'(dbg_state), int'(ST_RUN));
    expect_steps("ramp", 5, 1, 1, 10);
    wb_read(REG_STATUS, rd);
    check("ramp_status", int'(rd), 32'h1205);

    // Reversal from duty 5
    wb_write(REG_CTRL, 32'd3);
    expect_steps("drain", 5, 4, -1, 10);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("dead_entered", int'(dbg_state), int'(ST_DEAD));
    end while (motor_dir == 1'b0 && n < DEAD_CYCLES + 10);
    check("dead_time", n, DEAD_CYCLES + 1);
    check("dir_flipped", int'(motor_dir), 1);
    check("dead_exit_run", int'(dbg_state), int'(ST_RUN));
    expect_steps("reramp", 5, 1, 1, 10);

    // STEP_DIV=0 gives one step per cycle; ESTOP at duty 40
    wb_write(REG_STEP_DIV, 32'd0);
    wb_write(REG_TARGET, 32'd40);
    expect_steps("fast", 35, 6, 1, 1);
    wb_write(REG_CTRL, 32'd5);
    check("estop_duty", int'(duty_pct), 0);
    check("estop_duty_wr", int'(duty_wr), 1);
    check("estop_state", int'(dbg_state), int'(ST_IDLE));
    @(posedge clk); #1;
    check("estop_wr_single", int'(duty_wr), 0);
    wb_read(REG_CTRL, rd);   check("estop_ctrl", int'(rd), 0);
    wb_read(REG_STATUS, rd); check("estop_status", int'(rd), 32'h0100);

    // Cancelled reversal at duty 3
    wb_write(REG_STEP_DIV, 32'd10);
    wb_write(REG_TARGET, 32'd3);
    wb_write(REG_CTRL, 32'd3);
    expect_steps("cr_ramp", 3, 1, 1, 10);
    wb_write(REG_CTRL, 32'd1);
    @(posedge clk); #1;
    check("cr_drain", int'(dbg_state), int'(ST_DRAIN));
    wb_write(REG_CTRL, 32'd3);
    @(posedge clk); #1;
    check("cr_back_run", int'(dbg_state), int'(ST_RUN));
    check("cr_dir_kept", int'(motor_dir), 1);
    repeat (40) @(posedge clk);
    wb_read(REG_STATUS, rd);
    check("cr_status", int'(rd), 32'h1303);

    // Asynchronous reset at duty 20
    wb_write(REG_STEP_DIV, 32'd0);
    wb_write(REG_TARGET, 32'd30);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (duty_pct != 7'd20 && n < 60);
    check("mid_ramp_duty", int'(duty_pct), 20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_duty", int'(duty_pct), 0);
    check("arst_dir", int'(motor_dir), 0);
    check("arst_duty_wr", int'(duty_wr), 0);
    check("arst_state", int'(dbg_state), int'(ST_IDLE));
    check("arst_ack", int'(bus.wb_ack), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(REG_STEP_DIV, rd); check("arst_step_div", int'(rd), STEP_DIV_RST);
    wb_read(REG_TARGET, rd);   check("arst_target", int'(rd), 0);
    wb_read(REG_CTRL, rd);     check("arst_ctrl", int'(rd), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
